// File: rtl/data_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_pkg
// Shared definitions for the byte-addressed data memory:
//   - mem_mode_t    : access size encoding carried on mem_mode_i
//   - DMEM_DEFAULT_DEPTH / DMEM_MIN_DEPTH : size constants
//   - mode_nbytes() : number of bytes touched by an access of a given size
// Configuration macro used by the slice: DATA_MEMORY_SIGN_EXT_EN
// (see dmem_load_align).
// -----------------------------------------------------------------------------
package data_memory_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_mode_t;

  localparam int DMEM_DEFAULT_DEPTH = 1024;
  localparam int DMEM_MIN_DEPTH     = 8;

  // Byte count per access size. The reserved encoding touches nothing, which
  // is what makes a reserved-mode store a no-op.
  function automatic logic [2:0] mode_nbytes(input mem_mode_t mode);
    logic [2:0] n;
    n = 3'd0;
    case (mode)
      MEM_BYTE: n = 3'd1;
      MEM_HALF: n = 3'd2;
      MEM_WORD: n = 3'd4;
      default:  n = 3'd0;
    endcase
    return n;
  endfunction

endpackage : data_memory_pkg

// File: rtl/dmem_load_align.sv
// -----------------------------------------------------------------------------
// dmem_load_align
// Read-path formatting for data_memory: picks the bytes that belong to the
// access size and extends them to 32 bits.
//
// Configuration:
//   DATA_MEMORY_SIGN_EXT_EN defined   -> byte/halfword loads sign-extended
//   DATA_MEMORY_SIGN_EXT_EN undefined -> byte/halfword loads zero-extended
//   Word loads are identical in both builds.
//
// Ports:
//   raw_i   [31:0] : four bytes starting at the access address, byte 0 in [7:0]
//   mode_i  [1:0]  : access size (mem_mode_t encoding)
//   clear_i        : forces the result to zero (memory held in reset)
//   data_o  [31:0] : formatted load result
// -----------------------------------------------------------------------------
module dmem_load_align
  import data_memory_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  mode_i,
  input  logic        clear_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] byte_ext;
  logic [31:0] half_ext;

  assign byte_val = raw_i[7:0];
  assign half_val = raw_i[15:0];

`ifdef DATA_MEMORY_SIGN_EXT_EN
  assign byte_ext = {{24{byte_val[7]}}, byte_val};
  assign half_ext = {{16{half_val[15]}}, half_val};
`else
  assign byte_ext = {24'h0, byte_val};
  assign half_ext = {16'h0, half_val};
`endif

  always_comb begin
    data_o = 32'h0;
    if (!clear_i) begin
      case (mem_mode_t'(mode_i))
        MEM_BYTE: data_o = byte_ext;
        MEM_HALF: data_o = half_ext;
        MEM_WORD: data_o = raw_i;
        default:  data_o = 32'h0;
      endcase
    end
  end

endmodule : dmem_load_align

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Byte-addressed, little-endian data memory with unaligned, wrapping
// byte/halfword/word accesses. Stores happen on the rising clock edge; loads
// are combinational. Asynchronous reset clears every byte, so storage is
// built from flops rather than a RAM macro.
//
// Parameters:
//   DEPTH_BYTES : memory size in bytes, power of two, >= 8
//
// Ports:
//   clk_i            : clock, stores on rising edge
//   rst_i            : asynchronous active-high reset (clears memory)
//   write_enable_i   : 1 = store, 0 = load
//   write_data_i[31:0] : store data, byte 0 in [7:0]
//   a_i[31:0]        : byte address (taken modulo DEPTH_BYTES)
//   mem_mode_i[1:0]  : 00 byte, 01 halfword, 10 word, 11 reserved
//   read_data_o[31:0]: load result
//
// Configuration macro: DATA_MEMORY_SIGN_EXT_EN (load extension, applied in
// dmem_load_align).
// -----------------------------------------------------------------------------
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH_BYTES = DMEM_DEFAULT_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        write_enable_i,
  input  logic [31:0] write_data_i,
  input  logic [31:0] a_i,
  input  logic [1:0]  mem_mode_i,
  output logic [31:0] read_data_o
);

  localparam int AW = $clog2(DEPTH_BYTES);

  // Storage
  logic [7:0] mem [DEPTH_BYTES];

  // Access lanes: lane k addresses byte (a + k) mod DEPTH_BYTES. Because the
  // index is AW bits wide, the addition wraps from the last byte to byte 0
  // on its own. DEPTH_BYTES >= 8 keeps the four lanes distinct.
  logic [AW-1:0] base_idx;
  logic [AW-1:0] lane_addr [4];
  logic [3:0]    lane_en;
  logic [7:0]    lane_data [4];
  logic [2:0]    access_nbytes;

  // Address bits above the memory size are intentionally ignored.
  logic unused_addr_bits;

  assign base_idx      = a_i[AW-1:0];
  assign access_nbytes = mode_nbytes(mem_mode_t'(mem_mode_i));
  assign unused_addr_bits = ^a_i[31:AW];

  genvar gk;
  generate
    for (gk = 0; gk < 4; gk++) begin : g_lane
      assign lane_addr[gk] = base_idx + AW'(gk);
      assign lane_data[gk] = write_data_i[8*gk +: 8];
      assign lane_en[gk]   = write_enable_i && (3'(gk) < access_nbytes);
    end
  endgenerate

  // Per-byte write decode: each byte checks whether any active lane targets it.
  logic [DEPTH_BYTES-1:0] byte_we;
  logic [7:0]             byte_wd [DEPTH_BYTES];

  genvar gi, gj;
  generate
    for (gi = 0; gi < DEPTH_BYTES; gi++) begin : g_byte
      logic [3:0] hit;

      for (gj = 0; gj < 4; gj++) begin : g_hit
        assign hit[gj] = lane_en[gj] && (lane_addr[gj] == AW'(gi));
      end

      assign byte_we[gi] = |hit;

      always_comb begin
        byte_wd[gi] = 8'h00;
        if (hit[0])      byte_wd[gi] = lane_data[0];
        else if (hit[1]) byte_wd[gi] = lane_data[1];
        else if (hit[2]) byte_wd[gi] = lane_data[2];
        else if (hit[3]) byte_wd[gi] = lane_data[3];
      end
    end
  endgenerate

  // Reset wins over any store presented in the same cycle, so a store that
  // was pending when reset arrived never lands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        if (byte_we[i]) begin
          mem[i] <= byte_wd[i];
        end
      end
    end
  end

  // Read path: gather the four bytes at the access address; the aligner
  // keeps the ones the access size needs. Being combinational, a read of a
  // byte being stored shows the old value until the edge.
  logic [31:0] raw_word;

  assign raw_word = {mem[lane_addr[3]], mem[lane_addr[2]],
                     mem[lane_addr[1]], mem[lane_addr[0]]};

  dmem_load_align u_load_align (
    .raw_i   (raw_word),
    .mode_i  (mem_mode_i),
    .clear_i (rst_i),
    .data_o  (read_data_o)
  );

endmodule : data_memory

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
// Directed self-checking bench for data_memory (DEPTH_BYTES = 1024).
// Expected values for byte/halfword loads follow DATA_MEMORY_SIGN_EXT_EN.
// -----------------------------------------------------------------------------
module tb_data_memory;

  localparam int DEPTH = 1024;

`ifdef DATA_MEMORY_SIGN_EXT_EN
  localparam bit SX = 1'b1;
`else
  localparam bit SX = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        write_enable_i = 1'b0;
  logic [31:0] write_data_i = 32'h0;
  logic [31:0] a_i = 32'h0;
  logic [1:0]  mem_mode_i = 2'b10;
  logic [31:0] read_data_o;

  int n_cmp = 0;
  int n_bad = 0;

  data_memory #(.DEPTH_BYTES(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .write_enable_i (write_enable_i),
    .write_data_i   (write_data_i),
    .a_i            (a_i),
    .mem_mode_i     (mem_mode_i),
    .read_data_o    (read_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Present a store at the falling edge, commit it on the next rising edge.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] mode);
    @(negedge clk_i);
    a_i = addr; write_data_i = data; mem_mode_i = mode; write_enable_i = 1'b1;
    @(posedge clk_i);
    #1;
    write_enable_i = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] mode);
    write_enable_i = 1'b0;
    a_i = addr; mem_mode_i = mode;
    #1;
  endtask

  initial begin
    // Reset for 50 ns.
    #1;
    check_eq("reset_read", read_data_o, 32'h0);
    #49;
    rst_i = 1'b0;

    // Unaligned word store at address 1.
    do_store(32'd1, 32'h01C00F93, 2'b10);
    do_load(32'd1, 2'b10); check_eq("word_at_1", read_data_o, 32'h01C00F93);
    do_load(32'd1, 2'b00); check_eq("byte_at_1", read_data_o, SX ? 32'hFFFFFF93 : 32'h00000093);
    do_load(32'd2, 2'b00); check_eq("byte_at_2", read_data_o, 32'h0000000F);
    do_load(32'd3, 2'b00); check_eq("byte_at_3", read_data_o, SX ? 32'hFFFFFFC0 : 32'h000000C0);
    do_load(32'd4, 2'b00); check_eq("byte_at_4", read_data_o, 32'h00000001);
    do_load(32'd0, 2'b00); check_eq("byte_at_0", read_data_o, 32'h0);
    do_load(32'd1, 2'b01); check_eq("half_at_1", read_data_o, 32'h00000F93);
    do_load(32'd1, 2'b11); check_eq("rsvd_load", read_data_o, 32'h0);

    // Read-during-write: old data before the edge, new data after.
    @(negedge clk_i);
    a_i = 32'd20; write_data_i = 32'hDEADBEEF; mem_mode_i = 2'b10; write_enable_i = 1'b1;
    #1;
    check_eq("rdw_before_edge", read_data_o, 32'h0);
    @(posedge clk_i);
    #1;
    check_eq("rdw_after_edge", read_data_o, 32'hDEADBEEF);
    write_enable_i = 1'b0;

    // Load with write_enable_i=0 across an edge must not modify memory.
    @(negedge clk_i);
    a_i = 32'd20; write_data_i = 32'h11111111; mem_mode_i = 2'b10; write_enable_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_eq("no_we_no_write", read_data_o, 32'hDEADBEEF);

    // Word, then halfword and byte stores at address 8; reserved store ignored.
    do_store(32'd8, 32'h11223344, 2'b10);
    do_store(32'd8, 32'h0000CAFE, 2'b01);
    do_load(32'd8, 2'b10); check_eq("half_store", read_data_o, 32'h1122CAFE);
    do_store(32'd11, 32'hFFFFFF55, 2'b00);
    do_load(32'd8, 2'b10); check_eq("byte_store", read_data_o, 32'h5522CAFE);
    do_store(32'd8, 32'h12345678, 2'b11);
    do_load(32'd8, 2'b10); check_eq("rsvd_store_ignored", read_data_o, 32'h5522CAFE);
    do_load(32'd8, 2'b11); check_eq("rsvd_load_8", read_data_o, 32'h0);
    do_load(32'd8, 2'b01); check_eq("half_at_8", read_data_o, SX ? 32'hFFFFCAFE : 32'h0000CAFE);

    // Address bits above the memory size are ignored.
    do_load(32'd8 + 32'(DEPTH), 2'b10); check_eq("addr_alias", read_data_o, 32'h5522CAFE);

    // Asynchronous reset mid-cycle with a store pending.
    @(negedge clk_i);
    a_i = 32'd1; write_data_i = 32'h000F8083; mem_mode_i = 2'b10; write_enable_i = 1'b1;
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("async_rst_read", read_data_o, 32'h0);
    @(posedge clk_i);
    #1;
    check_eq("rst_store_ignored_rd", read_data_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    write_enable_i = 1'b0;
    do_load(32'd1, 2'b10); check_eq("after_rst_word_1", read_data_o, 32'h0);
    do_load(32'd8, 2'b10); check_eq("after_rst_word_8", read_data_o, 32'h0);
    do_load(32'd20, 2'b10); check_eq("after_rst_word_20", read_data_o, 32'h0);

    // Store after reset, sign/zero extension of negative half/byte.
    do_store(32'd1, 32'h000F8083, 2'b10);
    do_load(32'd1, 2'b01); check_eq("half_8083", read_data_o, SX ? 32'hFFFF8083 : 32'h00008083);
    do_load(32'd1, 2'b00); check_eq("byte_83", read_data_o, SX ? 32'hFFFFFF83 : 32'h00000083);
    do_load(32'd1, 2'b10); check_eq("word_8083", read_data_o, 32'h000F8083);

    // Wrap-around word store at DEPTH-2.
    do_store(32'(DEPTH - 2), 32'hAABBCCDD, 2'b10);
    do_load(32'(DEPTH - 2), 2'b10); check_eq("wrap_word", read_data_o, 32'hAABBCCDD);
    do_load(32'(DEPTH - 2), 2'b00); check_eq("wrap_byte_m2", read_data_o, SX ? 32'hFFFFFFDD : 32'h000000DD);
    do_load(32'(DEPTH - 1), 2'b00); check_eq("wrap_byte_m1", read_data_o, SX ? 32'hFFFFFFCC : 32'h000000CC);
    do_load(32'd0, 2'b00); check_eq("wrap_byte_0", read_data_o, SX ? 32'hFFFFFFBB : 32'h000000BB);
    do_load(32'd1, 2'b00); check_eq("wrap_byte_1", read_data_o, SX ? 32'hFFFFFFAA : 32'h000000AA);
    do_load(32'd2, 2'b00); check_eq("wrap_byte_2_kept", read_data_o, SX ? 32'hFFFFFF80 : 32'h00000080);
    do_load(32'(DEPTH - 1), 2'b01); check_eq("wrap_half", read_data_o, SX ? 32'hFFFFBBCC : 32'h0000BBCC);
    do_load(32'(DEPTH - 3), 2'b00); check_eq("wrap_neighbor", read_data_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000 ns");
    $fatal(1, "timeout");
  end

endmodule : tb_data_memory
